// File: rtl/controller_sequencer_if.sv
// Load/enable strobe bundle between the controller-sequencer and the
// bus-attached registers. The master drives strobes and ring state; the
// opcode comes back from the instruction register.
interface controller_sequencer_if;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo;
  logic       halt;

  modport master (
    input  opcode,
    output t_state, Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, halt
  );

  modport slave (
    output opcode,
    input  t_state, Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, halt
  );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring counter plus a combinational
// control-word decode of ring state and IR opcode. HLT freezes the ring in T4
// with every strobe parked at its inactive level until clr.
module controller_sequencer #(
  parameter int NT = 6
) (
  input  logic                   clk,
  input  logic                   clr,
  controller_sequencer_if.master bus
);

  typedef enum logic [NT-1:0] {
    T1 = NT'(1),
    T2 = NT'(2),
    T3 = NT'(4),
    T4 = NT'(8),
    T5 = NT'(16),
    T6 = NT'(32)
  } ring_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  ring_t state, state_nxt;
  logic  halt_q, halt_set;

  // Ring and halt flag; clr wins over both advance and halt.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= T1;
      halt_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (halt_set) halt_q <= 1'b1;
    end
  end

  // Next ring state; HLT in T4 holds the ring so it freezes in T4.
  // Any non-one-hot value falls through to T1.
  always_comb begin
    halt_set  = (state == T4) && (bus.opcode == OP_HLT) && !halt_q;
    state_nxt = state;
    if (!halt_q && !halt_set) begin
      case (state)
        T1:      state_nxt = T2;
        T2:      state_nxt = T3;
        T3:      state_nxt = T4;
        T4:      state_nxt = T5;
        T5:      state_nxt = T6;
        T6:      state_nxt = T1;
        default: state_nxt = T1;
      endcase
    end
  end

  // Control word decode. Fetch (T1..T3) ignores opcode since the IR only
  // loads on the T3->T4 edge. Only one bus driver is ever enabled per state.
  always_comb begin
    bus.Cp  = 1'b0;
    bus.Ep  = 1'b0;
    bus.nLm = 1'b1;
    bus.nCE = 1'b1;
    bus.nLi = 1'b1;
    bus.nEi = 1'b1;
    bus.nLa = 1'b1;
    bus.Ea  = 1'b0;
    bus.Su  = 1'b0;
    bus.Eu  = 1'b0;
    bus.nLb = 1'b1;
    bus.nLo = 1'b1;
    if (!halt_q) begin
      case (state)
        T1: begin
          bus.Ep  = 1'b1;
          bus.nLm = 1'b0;
        end
        T2: bus.Cp = 1'b1;
        T3: begin
          bus.nCE = 1'b0;
          bus.nLi = 1'b0;
        end
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              bus.nEi = 1'b0;
              bus.nLm = 1'b0;
            end
            OP_OUT: begin
              bus.Ea  = 1'b1;
              bus.nLo = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA: begin
              bus.nCE = 1'b0;
              bus.nLa = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              bus.nCE = 1'b0;
              bus.nLb = 1'b0;
              bus.Su  = (bus.opcode == OP_SUB);
            end
            default: ;
          endcase
        end
        T6: begin
          case (bus.opcode)
            OP_ADD, OP_SUB: begin
              bus.Eu  = 1'b1;
              bus.nLa = 1'b0;
              bus.Su  = (bus.opcode == OP_SUB);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.t_state = state;
  assign bus.halt    = halt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer. Stimulus drives clr/opcode once
// per cycle and queues the hand-derived control word for that cycle; a
// negedge monitor pops and compares whatever the DUT presents.
module tb_controller_sequencer;

  typedef struct packed {
    logic [5:0] ts;
    logic cp, ep, nlm, nce, nli, nei, nla, ea, su, eu, nlb, nlo, halt;
  } cw_t;

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;
  cw_t  expq[$];

  controller_sequencer_if bus ();

  controller_sequencer #(.NT(6)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Expected control word for T-state t (1..6), opcode op, halted flag h.
  function automatic cw_t exp_word(input int t, input logic [3:0] op, input bit h);
    cw_t w;
    w = '{ts: 6'd0, cp: 1'b0, ep: 1'b0, nlm: 1'b1, nce: 1'b1, nli: 1'b1,
          nei: 1'b1, nla: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, nlb: 1'b1,
          nlo: 1'b1, halt: h};
    w.ts = 6'd1 << (t - 1);
    if (!h) begin
      case (t)
        1: begin w.ep = 1'b1; w.nlm = 1'b0; end
        2: w.cp = 1'b1;
        3: begin w.nce = 1'b0; w.nli = 1'b0; end
        4: begin
          if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) begin
            w.nei = 1'b0; w.nlm = 1'b0;
          end else if (op == 4'b1110) begin
            w.ea = 1'b1; w.nlo = 1'b0;
          end
        end
        5: begin
          if (op == 4'b0000) begin
            w.nce = 1'b0; w.nla = 1'b0;
          end else if (op == 4'b0001 || op == 4'b0010) begin
            w.nce = 1'b0; w.nlb = 1'b0; w.su = (op == 4'b0010);
          end
        end
        6: begin
          if (op == 4'b0001 || op == 4'b0010) begin
            w.eu = 1'b1; w.nla = 1'b0; w.su = (op == 4'b0010);
          end
        end
        default: ;
      endcase
    end
    return w;
  endfunction

  // One cycle: drive inputs just after the edge and queue what this cycle
  // must show (state t was set by the edge just taken).
  task automatic cyc(input logic clr_v, input logic [3:0] op, input int t, input bit h);
    @(posedge clk);
    #1;
    clr        = clr_v;
    bus.opcode = op;
    expq.push_back(exp_word(t, op, h));
  endtask

  task automatic run_instr(input logic [3:0] op);
    for (int t = 1; t <= 6; t++) cyc(1'b0, op, t, 1'b0);
  endtask

  // Monitor: compare the queued word, then one-hot and bus exclusivity.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      cw_t e, a;
      int  drv;
      e = expq.pop_front();
      a = '{ts: bus.t_state, cp: bus.Cp, ep: bus.Ep, nlm: bus.nLm, nce: bus.nCE,
            nli: bus.nLi, nei: bus.nEi, nla: bus.nLa, ea: bus.Ea, su: bus.Su,
            eu: bus.Eu, nlb: bus.nLb, nlo: bus.nLo, halt: bus.halt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cw @%0t: got ts=%b word=%b, want ts=%b word=%b",
                 $time, a.ts, a[12:0], e.ts, e[12:0]);
      end
      total++;
      if ($countones(a.ts) != 1) begin
        bad++;
        $display("FAIL onehot @%0t: got t_state=%b, want one bit set", $time, a.ts);
      end
      drv = int'(a.ep) + int'(!a.nce) + int'(!a.nei) + int'(a.ea) + int'(a.eu);
      total++;
      if (drv > 1) begin
        bad++;
        $display("FAIL busexcl @%0t: got %0d drivers, want <=1", $time, drv);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got hang, want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    clr        = 1'b1;
    bus.opcode = 4'b0000;
    // clr sampled on two edges; the cycle after release is still T1.
    cyc(1'b1, 4'b0000, 1, 1'b0);
    run_instr(4'b0001);   // ADD
    run_instr(4'b0010);   // SUB
    run_instr(4'b0000);   // LDA
    run_instr(4'b1110);   // OUT
    run_instr(4'b0101);   // undefined -> NOP
    run_instr(4'b0111);   // undefined -> NOP
    // HLT: fetch + T4 normal, then frozen in T4 with strobes off.
    for (int t = 1; t <= 4; t++) cyc(1'b0, 4'b1111, t, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'b1111, 4, 1'b1);
    cyc(1'b1, 4'b1111, 4, 1'b1);   // clr pulse while halted
    // Recovery to T1 and an LDA that is reset during T5.
    for (int t = 1; t <= 4; t++) cyc(1'b0, 4'b0000, t, 1'b0);
    cyc(1'b1, 4'b0000, 5, 1'b0);
    run_instr(4'b0001);   // starts at T1 right after the mid-op clr
    run_instr(4'b0010);
    @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
